// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller: FSM state encoding,
// instruction opcode/op constants, mem_cmd and vsel codes, and the
// packed bundle of datapath control strobes.
package cpu_pkg;

   localparam int unsigned STATE_W = 5;

   typedef enum logic [STATE_W-1:0] {
      S_RST   = 5'd0,
      S_IF1   = 5'd1,
      S_IF2   = 5'd2,
      S_UPC   = 5'd3,
      S_DEC   = 5'd4,
      S_WIMM  = 5'd5,
      S_GETA  = 5'd6,
      S_GETB  = 5'd7,
      S_EXEC  = 5'd8,
      S_WREG  = 5'd9,
      S_ADDR  = 5'd10,
      S_LADDR = 5'd11,
      S_MRD1  = 5'd12,
      S_MRD2  = 5'd13,
      S_GETD  = 5'd14,
      S_SPASS = 5'd15,
      S_MWR   = 5'd16,
      S_HALT  = 5'd17
   } state_e;

   // Opcodes (IR[15:13])
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   // op field (IR[12:11]) for OPC_MOV
   localparam logic [1:0] OP_MOVR = 2'b00;
   localparam logic [1:0] OP_MOVI = 2'b10;

   // op field for OPC_ALU
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_CMP = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_MVN = 2'b11;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_PC    = 2'b01;
   localparam logic [1:0] VSEL_IMM8  = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

   typedef struct packed {
      logic [2:0] readnum;
      logic [2:0] writenum;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       asel;
      logic       bsel;
      logic       loadc;
      logic       loads;
      logic       write;
      logic [1:0] shift;
      logic [1:0] alu_op;
      logic       load_pc;
      logic       reset_pc;
      logic       addr_sel;
      logic       load_addr;
      logic [1:0] mem_cmd;
      logic       halted;
   } ctrl_t;

   // Control bundle presented while in RST
   function automatic ctrl_t ctrl_reset();
      ctrl_t c;
      c          = '0;
      c.reset_pc = 1'b1;
      c.load_pc  = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/instr_dec.sv
// Combinational instruction field extraction and sign extension.
// Ports: ir (instruction word) -> opcode, op, rn, rd, sh, rm, sximm5, sximm8.
module instr_dec #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] ir,
   output logic [2:0]       opcode,
   output logic [1:0]       op,
   output logic [2:0]       rn,
   output logic [2:0]       rd,
   output logic [1:0]       sh,
   output logic [2:0]       rm,
   output logic [WIDTH-1:0] sximm5,
   output logic [WIDTH-1:0] sximm8
);

   always_comb begin
      opcode = ir[15:13];
      op     = ir[12:11];
      rn     = ir[10:8];
      rd     = ir[7:5];
      sh     = ir[4:3];
      rm     = ir[2:0];
      sximm5 = {{(WIDTH-5){ir[4]}}, ir[4:0]};
      sximm8 = {{(WIDTH-8){ir[7]}}, ir[7:0]};
   end

endmodule

// File: rtl/vDFFE.sv
// Load-enabled register with asynchronous active-low clear.
// Ports: clk, rst_n (async clear), en (load), d (data in), q (data out).
module vDFFE #(
   parameter int unsigned N = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/cpu_control.sv
// Moore-FSM controller for the simple CPU: holds the instruction register,
// sequences fetch/decode/execute and drives datapath, PC and memory controls.
// Ports: clk, reset_n (async active-low), read_data (IR source);
// outputs are register-file addresses, datapath strobes, sign-extended
// immediates, PC/address controls, mem_cmd and halted.
module cpu_control
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] read_data,
   output logic [2:0]       readnum,
   output logic [2:0]       writenum,
   output logic [1:0]       vsel,
   output logic             loada,
   output logic             loadb,
   output logic             asel,
   output logic             bsel,
   output logic             loadc,
   output logic             loads,
   output logic             write,
   output logic [1:0]       shift,
   output logic [1:0]       ALUop,
   output logic [WIDTH-1:0] sximm5,
   output logic [WIDTH-1:0] sximm8,
   output logic             load_pc,
   output logic             reset_pc,
   output logic             addr_sel,
   output logic             load_addr,
   output logic [1:0]       mem_cmd,
   output logic             halted
);

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [WIDTH-1:0] sximm5_q, sximm8_q;
   logic [WIDTH-1:0] ir_q, ir_d;
   logic             load_ir;

   logic [2:0]       opcode, rn, rd, rm;
   logic [1:0]       op, sh;
   logic [WIDTH-1:0] dec_sximm5, dec_sximm8;

   assign load_ir = (state_q == S_IF2);

   vDFFE #(WIDTH) u_ir (
      .clk  (clk),
      .rst_n(reset_n),
      .en   (load_ir),
      .d    (read_data),
      .q    (ir_q)
   );

   // Value the IR holds after the coming edge; lets outputs be registered
   // while still reflecting the state/IR pair they belong to.
   assign ir_d = load_ir ? read_data : ir_q;

   instr_dec #(.WIDTH(WIDTH)) u_dec (
      .ir    (ir_d),
      .opcode(opcode),
      .op    (op),
      .rn    (rn),
      .rd    (rd),
      .sh    (sh),
      .rm    (rm),
      .sximm5(dec_sximm5),
      .sximm8(dec_sximm8)
   );

   // Next-state logic (IR is stable outside IF2, so decoded fields are valid)
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RST:  state_d = S_IF1;
         S_IF1:  state_d = S_IF2;
         S_IF2:  state_d = S_UPC;
         S_UPC:  state_d = S_DEC;
         S_DEC: begin
            case (opcode)
               OPC_MOV: begin
                  if (op == OP_MOVI)      state_d = S_WIMM;
                  else if (op == OP_MOVR) state_d = S_GETB;
                  else                    state_d = S_IF1;
               end
               OPC_ALU:          state_d = (op == OP_MVN) ? S_GETB : S_GETA;
               OPC_LDR, OPC_STR: state_d = S_GETA;
               OPC_HALT:         state_d = S_HALT;
               default:          state_d = S_IF1;
            endcase
         end
         S_WIMM:  state_d = S_IF1;
         S_GETA:  state_d = (opcode == OPC_LDR || opcode == OPC_STR) ? S_ADDR : S_GETB;
         S_GETB:  state_d = S_EXEC;
         S_EXEC:  state_d = (opcode == OPC_ALU && op == OP_CMP) ? S_IF1 : S_WREG;
         S_WREG:  state_d = S_IF1;
         S_ADDR:  state_d = S_LADDR;
         S_LADDR: state_d = (opcode == OPC_LDR) ? S_MRD1 : S_GETD;
         S_MRD1:  state_d = S_MRD2;
         S_MRD2:  state_d = S_IF1;
         S_GETD:  state_d = S_SPASS;
         S_SPASS: state_d = S_MWR;
         S_MWR:   state_d = S_IF1;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   // Output decode of the state being entered
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_RST: begin
            ctrl_d.reset_pc = 1'b1;
            ctrl_d.load_pc  = 1'b1;
         end
         S_IF1, S_IF2: begin
            ctrl_d.addr_sel = 1'b1;
            ctrl_d.mem_cmd  = MEM_READ;
         end
         S_UPC: ctrl_d.load_pc = 1'b1;
         S_WIMM: begin
            ctrl_d.writenum = rn;
            ctrl_d.vsel     = VSEL_IMM8;
            ctrl_d.write    = 1'b1;
         end
         S_GETA: begin
            ctrl_d.readnum = rn;
            ctrl_d.loada   = 1'b1;
         end
         S_GETB: begin
            ctrl_d.readnum = rm;
            ctrl_d.loadb   = 1'b1;
         end
         S_EXEC: begin
            ctrl_d.shift  = sh;
            ctrl_d.loadc  = 1'b1;
            // MOV-register passes B through the adder with A gated off
            ctrl_d.alu_op = (opcode == OPC_MOV) ? 2'b00 : op;
            ctrl_d.asel   = (opcode == OPC_MOV) || (op == OP_MVN);
            ctrl_d.loads  = (opcode == OPC_ALU) && (op == OP_CMP);
         end
         S_WREG: begin
            ctrl_d.writenum = rd;
            ctrl_d.vsel     = VSEL_C;
            ctrl_d.write    = 1'b1;
         end
         S_ADDR: begin
            ctrl_d.bsel  = 1'b1;
            ctrl_d.loadc = 1'b1;
         end
         S_LADDR: ctrl_d.load_addr = 1'b1;
         S_MRD1:  ctrl_d.mem_cmd   = MEM_READ;
         S_MRD2: begin
            ctrl_d.mem_cmd  = MEM_READ;
            ctrl_d.vsel     = VSEL_MDATA;
            ctrl_d.writenum = rd;
            ctrl_d.write    = 1'b1;
         end
         S_GETD: begin
            ctrl_d.readnum = rd;
            ctrl_d.loadb   = 1'b1;
         end
         S_SPASS: begin
            ctrl_d.asel  = 1'b1;
            ctrl_d.loadc = 1'b1;
         end
         S_MWR:  ctrl_d.mem_cmd = MEM_WRITE;
         S_HALT: ctrl_d.halted  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_RST;
         ctrl_q   <= ctrl_reset();
         sximm5_q <= '0;
         sximm8_q <= '0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         sximm5_q <= dec_sximm5;
         sximm8_q <= dec_sximm8;
      end
   end

   assign readnum   = ctrl_q.readnum;
   assign writenum  = ctrl_q.writenum;
   assign vsel      = ctrl_q.vsel;
   assign loada     = ctrl_q.loada;
   assign loadb     = ctrl_q.loadb;
   assign asel      = ctrl_q.asel;
   assign bsel      = ctrl_q.bsel;
   assign loadc     = ctrl_q.loadc;
   assign loads     = ctrl_q.loads;
   assign write     = ctrl_q.write;
   assign shift     = ctrl_q.shift;
   assign ALUop     = ctrl_q.alu_op;
   assign load_pc   = ctrl_q.load_pc;
   assign reset_pc  = ctrl_q.reset_pc;
   assign addr_sel  = ctrl_q.addr_sel;
   assign load_addr = ctrl_q.load_addr;
   assign mem_cmd   = ctrl_q.mem_cmd;
   assign halted    = ctrl_q.halted;
   assign sximm5    = sximm5_q;
   assign sximm8    = sximm8_q;

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 SHALL have parameter WIDTH = 16, the instruction and immediate width.
REQ-002 SHALL have `clk` (input, 1): the single clock; all state changes on its rising edge.
REQ-003 SHALL have `reset_n` (input, 1): asynchronous, active-low reset.
REQ-004 SHALL have `read_data` (input, 16): memory read word; loaded into the IR.
REQ-005 SHALL have `readnum` and `writenum` (output, 3 each): register-file addresses to the datapath.
REQ-006 SHALL have `vsel` (output, 2): write-back source select; 00 = C, 01 = PC, 10 = sximm8, 11 = mdata.
REQ-007 SHALL have the datapath control strobes `loada`, `loadb`, `asel`, `bsel`, `loadc`, `loads`, `write` (output, 1 each).
REQ-008 SHALL have `shift` and `ALUop` (output, 2 each).
REQ-009 SHALL have `sximm5` and `sximm8` (output, 16 each): sign-extended IR[4:0] and IR[7:0].
REQ-010 SHALL have `load_pc`, `reset_pc`, `addr_sel`, `load_addr` (output, 1 each): PC and address-register control.
REQ-011 SHALL have `mem_cmd` (output, 2): 00 = NONE, 01 = READ, 10 = WRITE.
REQ-012 SHALL have `halted` (output, 1): high only in state HALT.

Function
REQ-013 SHALL hold a 16-bit IR, loaded from `read_data` on a clock edge where `load_ir` is asserted (internal signal, IF2 only).
REQ-014 SHALL decode IR fields as: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
REQ-015 SHALL be a Moore FSM; outputs are a function of state and IR only. Any output not listed for a state SHALL be 0.
REQ-016 SHALL sequence instruction fetch as RST -> IF1 -> IF2 -> UPC -> DEC.
  - RST: reset_pc = 1, load_pc = 1.
  - IF1: addr_sel = 1, mem_cmd = READ.
  - IF2: addr_sel = 1, mem_cmd = READ, load_ir = 1.
  - UPC: load_pc = 1.
REQ-017 SHALL execute MOV-immediate (opcode 110, op 10) as DEC -> WIMM -> IF1; WIMM drives writenum = Rn, vsel = 10, write = 1.
REQ-018 SHALL execute ALU instructions (opcode 101; opcode 110 with op 00).
  - ADD, CMP, AND (opcode 101, op 00/01/10) go DEC -> GETA -> GETB; GETA drives readnum = Rn, loada = 1.
  - MOV-register and MVN go DEC -> GETB directly.
  - GETB: readnum = Rm, loadb = 1.
  - EXEC: shift = sh, loadc = 1.
  - ALUop = op, except MOV-register, which drives ALUop = 00.
  - asel = 1 for MOV-register and MVN.
REQ-019 SHALL, in EXEC, assert loads = 1 for CMP only and then go to IF1; every other ALU instruction goes EXEC -> WREG.
REQ-020 SHALL, in WREG, drive writenum = Rd, vsel = 00, write = 1, then go to IF1.
REQ-021 SHALL compute the LDR (opcode 011) and STR (opcode 100) address as DEC -> GETA -> ADDR -> LADDR.
  - ADDR: asel = 0, bsel = 1, ALUop = 00, shift = 00, loadc = 1.
  - LADDR: load_addr = 1.
REQ-022 SHALL complete LDR as LADDR -> MRD1 -> MRD2 -> IF1.
  - MRD1: addr_sel = 0, mem_cmd = READ.
  - MRD2: mem_cmd = READ, vsel = 11, writenum = Rd, write = 1.
REQ-023 SHALL complete STR as LADDR -> GETD -> SPASS -> MWR -> IF1.
  - GETD: readnum = Rd, loadb = 1.
  - SPASS: asel = 1, bsel = 0, ALUop = 00, shift = 00, loadc = 1.
  - MWR: addr_sel = 0, mem_cmd = WRITE.
REQ-024 SHALL send HALT (opcode 111) from DEC to HALT and hold there indefinitely, with halted = 1 and mem_cmd = NONE, until reset_n is asserted.
REQ-025 SHALL treat undefined opcode/op combinations as NOP: DEC -> IF1, with no write, loads or mem_cmd.
REQ-026 SHALL give instruction latency, counted from IF1 entry to the next IF1 entry:
  - MOV-immediate: 5 cycles.
  - MOV-register and MVN: 7 cycles.
  - ADD and AND: 8 cycles.
  - CMP: 7 cycles.
  - LDR: 9 cycles.
  - STR: 10 cycles.

Reset
REQ-027 SHALL, while reset_n = 0, asynchronously force the state to RST and the IR to 0x0000.
REQ-028 SHALL have every output except reset_pc and load_pc at 0 while in RST.
REQ-029 SHALL, on a reset assertion mid-instruction, abandon the instruction: no further write, loads or mem_cmd WRITE occurs.
REQ-030 SHALL leave RST on the first rising clock edge after reset_n = 1 and enter IF1.

Structure
REQ-031 SHALL take the state encodings, opcode/op constants and mem_cmd codes from a shared package, cpu_pkg.
REQ-032 SHALL place the combinational field extraction and sign extension in one sub-module, instr_dec.
REQ-033 SHALL implement the IR with the existing vDFFE #(16) plus the asynchronous clear.

Verification
REQ-034 SHALL cover MOV-immediate: read_data = 0xD0FB (MOV R0,#-5) -> WIMM shows writenum = 0, vsel = 10, write = 1, sximm8 = 0xFFFB; IF1 is re-entered 5 cycles after the previous IF1.
REQ-035 SHALL cover ADD: 0xA148 (ADD R2,R1,R0,LSL#1) -> GETA readnum = 1; GETB readnum = 0; EXEC shift = 01, ALUop = 00, loadc = 1; WREG writenum = 2.
REQ-036 SHALL cover CMP: 0xA900 (CMP R1,R0) -> EXEC loads = 1; write is never asserted; next state after EXEC is IF1.
REQ-037 SHALL cover LDR: 0x6164 (LDR R3,[R1,#4]) -> ADDR bsel = 1 with sximm5 = 0x0004; LADDR load_addr = 1; MRD2 vsel = 11, writenum = 3, write = 1.
REQ-038 SHALL cover HALT: 0xE000 -> halted = 1 and mem_cmd = 00 for at least 20 cycles; a reset_n pulse then returns the FSM to RST with reset_pc = 1.
REQ-039 SHALL cover reset during STR: reset_n driven low in GETD -> mem_cmd WRITE never appears; after release the sequence is RST -> IF1.
